sram_ctrl: RTL and testbench
============================

# sram_ctrl

Synchronous initiator for the external IS61C5128 asynchronous 512K×8 SRAM. It turns a single-client request/ready host port into correctly sequenced `ce_l`/`oe_l`/`we_l`/address/data activity on the SRAM pins. Read access time and write pulse width are set by a cycle-count parameter. It sits between the video/CPU memory arbiter and the board-level SRAM pads; all pin outputs are registered, so they are glitch-free.

## Interface
- `ADDR_WIDTH`, default 19: SRAM address width.
- `ACCESS_CYCLES`, default 2: cycles for the read access window and for the `we_l` low pulse; minimum 1; at 57 MHz, 2 cycles is ≥ 10 ns tAA/tPWE.
- `clk  in  1`: sole clock.
- `reset  in  1`: asynchronous, active-high.
- `req  in  1`: host request valid.
- `we  in  1`: 1 = write, 0 = read; sampled with `req`.
- `addr  in  ADDR_WIDTH`: host address; sampled with `req`.
- `wdata  in  8`: write data; sampled with `req`.
- `ready  out  1`: controller is in IDLE; the request is accepted on an edge where `req & ready`.
- `rdata  out  8`: captured read data; held until the next read completes.
- `rvalid  out  1`: one-cycle pulse; `rdata` is valid.
- `wdone  out  1`: one-cycle pulse; write cycle finished.
- `sram_addr  out  ADDR_WIDTH`: SRAM address pins.
- `sram_data  inout  8`: SRAM data pins; driven only during write states.
- `sram_ce_l`, `sram_oe_l`, `sram_we_l  out  1 each`: active-low SRAM strobes.

## Operation
- States and pin values:
  - IDLE: all strobes high, data hi-Z.
  - RD: `ce_l=0`, `oe_l=0`, `we_l=1`, data hi-Z.
  - WR_SETUP: `ce_l=0`, `oe_l=1`, `we_l=1`, data driven.
  - WR_PULSE: `ce_l=0`, `oe_l=1`, `we_l=0`, data driven.
  - WR_HOLD: `ce_l=0`, `oe_l=1`, `we_l=1`, data driven.
- Transitions:
  - IDLE → RD or WR_SETUP on `req & ready`. `addr`/`wdata` are latched into `sram_addr` and the data output register on the same edge.
  - RD lasts ACCESS_CYCLES cycles, then → IDLE. On the exit edge `rdata <= sram_data` and `rvalid` is set for one cycle.
  - WR_SETUP lasts 1 cycle → WR_PULSE.
  - WR_PULSE lasts ACCESS_CYCLES cycles → WR_HOLD.
  - WR_HOLD lasts 1 cycle → IDLE, with `wdone` pulsed.
- `sram_addr` is held constant from acceptance until the return to IDLE. In IDLE it holds the last address; there is no address change while `ce_l` is low.
- The data bus is never driven while `oe_l=0`; contention-free by construction.
- Down-counter width is `$clog2(ACCESS_CYCLES+1)`. It is loaded with ACCESS_CYCLES−1 on state entry and the state exits when it reaches 0.
- `req` in a non-IDLE state is ignored; the host holds it until `ready`.

## Timing
- Reset values: `ready=1`, `rvalid=0`, `wdone=0`, `rdata=0x00`, `sram_addr=0`, all strobes 1, data hi-Z, state IDLE.
- Read latency: accepted at edge E0, `rvalid` high during the cycle after edge E0+ACCESS_CYCLES. The earliest next acceptance is at edge E0+ACCESS_CYCLES+1.
- Write occupancy: ACCESS_CYCLES+2 cycles; `wdone` high in the cycle after edge E0+ACCESS_CYCLES+2.
- Hold margins: address and data are held one full cycle after the `we_l` rising edge. This covers the SRAM's 10 ns address path and 0 ns data hold.
- `ready` is a combinational decode of state == IDLE; no other host output is combinational.
- Reset mid-operation: all outputs go to reset values asynchronously. If reset lands in WR_PULSE, `we_l` rises and that write may commit with the latched address/data. This is accepted behaviour; a read in progress is dropped with no `rvalid`.

## Structure
- Shared package `gg_sram_pkg` holds:
  - the state encoding constants (IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD);
  - the default ACCESS_CYCLES;
  - the SRAM address width constant.
- Single module, no sub-modules. The tristate is one continuous assign from a registered `data_oe` and data register.

## Test plan
- The bench connects the IS61C5128 behavioral model, preloaded with `array[i] = i & 0xFF`.
- Read `addr=0x005` with ACCESS_CYCLES=2 → `rvalid` at edge E0+2, `rdata=0x05`, `oe_l` low for exactly 2 cycles.
- Write `0xA5` to `0x010`, then read `0x010` → `wdone` after 4 cycles, `we_l` low for exactly 2 cycles, read returns `0xA5`.
- Back-to-back `req` held high with a read then a write → `ready` low during each op. A second accept occurs only after IDLE; assertions check `sram_data` is never driven while `oe_l=0` and `sram_addr` never changes while `ce_l=0`.
- ACCESS_CYCLES=1 build: read `0x3FF` → `0xFF` at edge E0+1; write occupancy is 3 cycles.
- Assert reset during the read state → strobes return to 1 immediately, no `rvalid`, and `ready=1` after release. Reset during WR_PULSE of `0x77`→`0x020` → the bench accepts either `0x77` or the old `0x20` on readback.
- Randomized `req`/`we`/`addr` < 0x400 against a scoreboard mirror of the array → all reads match.

Source files
------------

// File: rtl/gg_sram_pkg.sv
// gg_sram_pkg: shared state encoding and default sizing for the SRAM initiator.
package gg_sram_pkg;
    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
    localparam int DEF_ACCESS_CYCLES = 2;
    localparam int SRAM_ADDR_WIDTH = 19;
endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: sequences ce_l/oe_l/we_l/address/data for an asynchronous 512Kx8 SRAM from a req/ready host port.
module sram_ctrl
    import gg_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            wdata,
    output logic                  ready,
    output logic [7:0]            rdata,
    output logic                  rvalid,
    output logic                  wdone,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [7:0]            sram_data,
    output logic                  sram_ce_l,
    output logic                  sram_oe_l,
    output logic                  sram_we_l
);
    localparam int CW = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(ACCESS_CYCLES - 1);

    state_t state, next;
    logic [CW-1:0] cnt, cnt_next;
    logic [7:0] dout;
    logic data_oe;

    assign ready = state == IDLE;
    assign sram_data = data_oe ? dout : 8'bz;

    always_comb begin
        next = state;
        cnt_next = cnt;
        case (state)
            IDLE: if (req) begin
                next = we ? WR_SETUP : RD;
                cnt_next = LOAD;
            end
            RD: if (cnt == '0) next = IDLE; else cnt_next = cnt - 1'b1;
            WR_SETUP: begin
                next = WR_PULSE;
                cnt_next = LOAD;
            end
            WR_PULSE: if (cnt == '0) next = WR_HOLD; else cnt_next = cnt - 1'b1;
            WR_HOLD: next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Pin strobes are registered from the next state so they change exactly on state entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            sram_addr <= '0;
            dout <= '0;
            data_oe <= 1'b0;
            sram_ce_l <= 1'b1;
            sram_oe_l <= 1'b1;
            sram_we_l <= 1'b1;
            rdata <= '0;
            rvalid <= 1'b0;
            wdone <= 1'b0;
        end else begin
            state <= next;
            cnt <= cnt_next;
            sram_ce_l <= next == IDLE;
            sram_oe_l <= next != RD;
            sram_we_l <= next != WR_PULSE;
            data_oe <= next inside {WR_SETUP, WR_PULSE, WR_HOLD};
            rvalid <= state == RD && next == IDLE;
            wdone <= state == WR_HOLD;
            if (state == IDLE && req) begin
                sram_addr <= addr;
                dout <= wdata;
            end
            if (state == RD && next == IDLE) rdata <= sram_data;
        end
    end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: scoreboard bench for sram_ctrl with behavioral IS61C5128 models (ACCESS_CYCLES 2 and 1).
module tb_sram_ctrl;
    localparam int AC = 2;
    localparam int AW = 19;
    localparam int AW1 = 10;

    typedef struct {
        bit         wr;
        logic [7:0] d;
        logic [7:0] alt;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic req = 1'b0, we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [7:0] wdata = '0;
    logic ready, rvalid, wdone, ce_l, oe_l, we_l;
    logic [7:0] rdata;
    logic [AW-1:0] sram_addr;
    wire [7:0] sram_data;

    sram_ctrl #(.ADDR_WIDTH(AW), .ACCESS_CYCLES(AC)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .rvalid(rvalid), .wdone(wdone),
        .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_ce_l(ce_l), .sram_oe_l(oe_l), .sram_we_l(we_l)
    );

    logic req1 = 1'b0, we1 = 1'b0;
    logic [AW1-1:0] addr1 = '0;
    logic [7:0] wdata1 = '0;
    logic ready1, rvalid1, wdone1, ce1_l, oe1_l, we1_l;
    logic [7:0] rdata1;
    logic [AW1-1:0] sram_addr1;
    wire [7:0] sram_data1;

    sram_ctrl #(.ADDR_WIDTH(AW1), .ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
        .ready(ready1), .rdata(rdata1), .rvalid(rvalid1), .wdone(wdone1),
        .sram_addr(sram_addr1), .sram_data(sram_data1),
        .sram_ce_l(ce1_l), .sram_oe_l(oe1_l), .sram_we_l(we1_l)
    );

    // Behavioral SRAMs: drive on read, capture address/data while we_l is low, commit on its rising edge.
    logic [7:0] mem0 [0:(1<<AW)-1];
    logic [7:0] exp_mem [0:(1<<AW)-1];
    logic [7:0] mem1 [0:(1<<AW1)-1];
    logic [AW-1:0] wa0 = '0;
    logic [7:0] wd0 = '0;
    logic [AW1-1:0] wa1 = '0;
    logic [7:0] wd1 = '0;

    assign sram_data = (!ce_l && !oe_l && we_l) ? mem0[sram_addr] : 8'bz;
    assign sram_data1 = (!ce1_l && !oe1_l && we1_l) ? mem1[sram_addr1] : 8'bz;
    always @(negedge clk) if (!ce_l && !we_l) begin wa0 <= sram_addr; wd0 <= sram_data; end
    always @(negedge clk) if (!ce1_l && !we1_l) begin wa1 <= sram_addr1; wd1 <= sram_data1; end
    always @(posedge we_l) mem0[wa0] <= wd0;
    always @(posedge we1_l) mem1[wa1] <= wd1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    exp_t q[$];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", n, act, e, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every rvalid/wdone and watches pin protocol.
    initial begin
        exp_t e;
        int oe_n, we_n;
        logic pce;
        logic [AW-1:0] paddr;
        oe_n = 0; we_n = 0; pce = 1'b0; paddr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                oe_n = 0; we_n = 0; pce = 1'b0;
            end else begin
                if (rvalid || wdone) begin
                    if (q.size() == 0) chk("unexpected_pulse", {30'b0, rvalid, wdone}, 32'd0);
                    else begin
                        e = q.pop_front();
                        chk("pulse_kind", {30'b0, rvalid, wdone}, e.wr ? 32'd1 : 32'd2);
                        chk("latency", cyc, e.due);
                        if (!e.wr) chk("rdata", {24'b0, rdata}, {24'b0, (rdata === e.alt) ? e.alt : e.d});
                    end
                end
                if (!oe_l) oe_n++;
                else if (oe_n != 0) begin chk("oe_low_cycles", oe_n, AC); oe_n = 0; end
                if (!we_l) we_n++;
                else if (we_n != 0) begin chk("we_low_cycles", we_n, AC); we_n = 0; end
                if (!ce_l && pce) chk("addr_stable", {13'b0, sram_addr}, {13'b0, paddr});
                if (!oe_l) chk("read_bus", {24'b0, sram_data}, {24'b0, mem0[sram_addr]});
                pce = !ce_l;
                paddr = sram_addr;
            end
        end
    end

    task automatic issue(input bit w, input logic [AW-1:0] a, input logic [7:0] d, input bit keep, input int alt = -1);
        exp_t e;
        int n;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        n = 0;
        while (!ready && n < 50) begin @(negedge clk); n++; end
        if (!ready) begin chk("ready_timeout", 32'd0, 32'd1); req = 1'b0; return; end
        e.wr = w;
        e.d = w ? d : exp_mem[a];
        e.alt = (alt >= 0) ? alt[7:0] : e.d;
        e.due = cyc + 1 + AC + (w ? 2 : 0);
        q.push_back(e);
        if (w) exp_mem[a] = d;
        @(posedge clk);
        #1;
        chk("ready_low_busy", {31'b0, ready}, 32'd0);
        if (!keep) req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("drain", q.size(), 32'd0);
    endtask

    task automatic op1(input bit w, input logic [AW1-1:0] a, input logic [7:0] d, input logic [7:0] ed);
        int e0, n;
        @(negedge clk);
        chk("u1_ready", {31'b0, ready1}, 32'd1);
        req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        e0 = cyc + 1;
        @(posedge clk);
        #1 req1 = 1'b0;
        n = 0;
        while (!(w ? wdone1 : rvalid1) && n < 20) begin @(negedge clk); n++; end
        chk("u1_latency", cyc, e0 + (w ? 3 : 1));
        if (!w) chk("u1_rdata", {24'b0, rdata1}, {24'b0, ed});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] ra;
        for (int i = 0; i < (1 << AW); i++) begin mem0[i] = i[7:0]; exp_mem[i] = i[7:0]; end
        for (int i = 0; i < (1 << AW1); i++) mem1[i] = i[7:0];
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_wdone", {31'b0, wdone}, 32'd0);
        chk("rst_rdata", {24'b0, rdata}, 32'd0);
        chk("rst_addr", {13'b0, sram_addr}, 32'd0);
        chk("rst_strobes", {29'b0, ce_l, oe_l, we_l}, 32'd7);

        issue(0, 19'h005, 8'h00, 0);
        issue(1, 19'h010, 8'hA5, 0);
        issue(0, 19'h010, 8'h00, 0);
        drain();

        issue(0, 19'h033, 8'h00, 1);
        issue(1, 19'h034, 8'h5C, 1);
        issue(0, 19'h034, 8'h00, 0);
        drain();

        // Reset while the read strobes are active: no rvalid may follow.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 19'h005;
        @(posedge clk);
        #1 req = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rd_rst_strobes", {29'b0, ce_l, oe_l, we_l}, 32'd7);
        chk("rd_rst_rvalid", {31'b0, rvalid}, 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("rd_rst_ready", {31'b0, ready}, 32'd1);

        // Reset during the write pulse: either old or new data is legal on readback.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 19'h020; wdata = 8'h77;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("wr_rst_strobes", {29'b0, ce_l, oe_l, we_l}, 32'd7);
        @(negedge clk);
        #1 reset = 1'b0;
        issue(0, 19'h020, 8'h00, 0, 32'h77);
        issue(1, 19'h020, 8'h20, 0);
        drain();

        for (int i = 0; i < 60; i++) begin
            ra = AW'($urandom_range(0, 1023));
            issue(1'($urandom_range(0, 1)), ra, 8'($urandom), 1'($urandom_range(0, 1)));
        end
        req = 1'b0;
        drain();

        op1(0, 10'h3FF, 8'h00, 8'hFF);
        op1(1, 10'h155, 8'h3C, 8'h00);
        op1(0, 10'h155, 8'h00, 8'h3C);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
